// File: rtl/col_inverse_processor.sv
// Column inverse CDF 5/3 lifting stage.
// Rebuilds the even/odd row pair of the previous pass, one column per clock.
module col_inverse_processor #(
    parameter int LENGTH = 256
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       first,
    input  logic       flush,
    input  logic [7:0] s_in,
    input  logic [7:0] d_in,
    output logic [7:0] even_row,
    output logic [7:0] odd_row,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    localparam int AW = $clog2(LENGTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROC,
        ST_DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            first_q, first_nx;
    logic            flush_q, flush_nx;
    logic            last;
    logic            proc;
    logic            mirror;
    logic [AW-1:0]   addr;

    logic [7:0]        dbank [LENGTH];
    logic [7:0]        ebank [LENGTH];
    logic signed [9:0] d_new, d_old;
    logic signed [9:0] dc, dp;
    logic signed [9:0] dsum, lift;
    logic [7:0]        ep, ec;
    logic [8:0]        esum;
    logic [7:0]        o;

    assign last   = (cnt == CW'(LENGTH - 1));
    assign proc   = (state == ST_PROC);
    // first wins over flush: a lone pair cannot be mirrored
    assign mirror = flush_q & ~first_q;
    assign addr   = cnt[AW-1:0];
    assign busy   = (state != ST_IDLE);

    // State, column counter and latched pass flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            first_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            first_q <= first_nx;
            flush_q <= flush_nx;
        end
    end

    // Next-state logic: idle -> one column per cycle -> single done cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        first_nx = first_q;
        flush_nx = flush_q;
        unique case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nx = ST_PROC;
                    cnt_nx   = '0;
                    first_nx = first;
                    flush_nx = flush;
                end
            end
            ST_PROC: begin
                cnt_nx = cnt + 1'b1;
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Lifting datapath for the current column
    always_comb begin
        d_new = {{2{d_in[7]}}, d_in};
        d_old = {{2{dbank[addr][7]}}, dbank[addr]};
        ep    = ebank[addr];
        dc    = mirror ? d_old : d_new;
        dp    = first_q ? dc : d_old;
        dsum  = dp + dc + 10'sd2;
        lift  = dsum >>> 2;
        ec    = mirror ? ep : 8'({2'b00, s_in} - lift);
        esum  = {1'b0, ep} + {1'b0, ec};
        o     = 8'(dp + 10'(esum >> 1));
    end

    // Line banks keep the previous d row and even row; not reset
    always_ff @(posedge clk) begin
        if (proc && !mirror) begin
            dbank[addr] <= d_in;
            ebank[addr] <= ec;
        end
    end

    // Registered outputs; pair data only moves once a full pair exists
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            even_row  <= '0;
            odd_row   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= proc & ~first_q;
            done      <= proc & last;
            if (proc && !first_q) begin
                even_row <= ep;
                odd_row  <= o;
            end
        end
    end

endmodule

// File: tb/tb_col_inverse_processor.sv
// Directed bench for col_inverse_processor (LENGTH=4).
// Table of constant passes plus round-trip and reset sequences.
module tb_col_inverse_processor;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       first = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] s_in = '0;
    logic [7:0] d_in = '0;
    logic [7:0] even_row, odd_row;
    logic       out_valid, busy, done;

    col_inverse_processor #(.LENGTH(L)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .first     (first),
        .flush     (flush),
        .s_in      (s_in),
        .d_in      (d_in),
        .even_row  (even_row),
        .odd_row   (odd_row),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] s_vec [L];
    logic [7:0] d_vec [L];
    logic [7:0] g_even [L];
    logic [7:0] g_odd [L];
    logic       g_valid [L];
    logic       g_done [L];

    typedef struct {
        logic       f;
        logic       fl;
        logic       pk;
        logic [7:0] s;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ee;
        logic [7:0] eo;
    } vec_t;

    vec_t tbl [8];

    logic [7:0] rx [8][L];
    logic [7:0] rs [4][L];
    logic [7:0] rd [4][L];

    function automatic vec_t mk(
        input logic f, input logic fl, input logic pk,
        input logic [7:0] s, input logic [7:0] d,
        input logic ev, input logic [7:0] ee, input logic [7:0] eo
    );
        vec_t v;
        v.f = f; v.fl = fl; v.pk = pk;
        v.s = s; v.d = d;
        v.ev = ev; v.ee = ee; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One full pass; en pulse is driven on a falling edge, columns follow
    task automatic run_pass(input logic f, input logic fl, input logic pk);
        @(negedge clk);
        en = 1'b1; first = f; flush = fl;
        @(negedge clk);
        en = 1'b0; first = 1'b0; flush = 1'b0;
        chk("busy_start", 32'(busy), 1);
        chk("valid_before", 32'(out_valid), 0);
        for (int c = 0; c <= L; c++) begin
            if (c > 0) begin
                g_even[c-1]  = even_row;
                g_odd[c-1]   = odd_row;
                g_valid[c-1] = out_valid;
                g_done[c-1]  = done;
                if (c < L) chk("busy_mid", 32'(busy), 1);
            end
            if (c < L) begin
                s_in  = s_vec[c];
                d_in  = d_vec[c];
                en    = pk && (c == 1);
                first = pk && (c == 1);
                @(negedge clk);
            end
        end
        en = 1'b0; first = 1'b0;
        chk("busy_in_done", 32'(busy), 1);
        @(negedge clk);
        chk("busy_after", 32'(busy), 0);
        chk("valid_after", 32'(out_valid), 0);
        chk("done_after", 32'(done), 0);
    endtask

    task automatic check_pass(input string tag, input logic ev,
                              input logic [7:0] ee [L],
                              input logic [7:0] eo [L]);
        for (int c = 0; c < L; c++) begin
            chk({tag, "_valid"}, 32'(g_valid[c]), 32'(ev));
            chk({tag, "_done"}, 32'(g_done[c]), (c == L-1) ? 1 : 0);
            if (ev) begin
                chk({tag, "_even"}, 32'(g_even[c]), 32'(ee[c]));
                chk({tag, "_odd"}, 32'(g_odd[c]), 32'(eo[c]));
            end
        end
    endtask

    logic [7:0] ee [L];
    logic [7:0] eo [L];

    initial begin
        tbl[0] = mk(1, 0, 0, 8'd100, 8'h00, 0, 8'd0, 8'd0);
        tbl[1] = mk(0, 0, 1, 8'd100, 8'h00, 1, 8'd100, 8'd100);
        tbl[2] = mk(1, 0, 0, 8'd50, 8'hFC, 0, 8'd0, 8'd0);
        tbl[3] = mk(0, 1, 0, 8'hAA, 8'h55, 1, 8'd52, 8'd48);
        tbl[4] = mk(1, 0, 0, 8'd2, 8'h7F, 0, 8'd0, 8'd0);
        tbl[5] = mk(0, 1, 0, 8'h00, 8'h80, 1, 8'd194, 8'd65);
        tbl[6] = mk(1, 1, 0, 8'd100, 8'h00, 0, 8'd0, 8'd0);
        tbl[7] = mk(0, 0, 0, 8'd100, 8'h00, 1, 8'd100, 8'd100);

        repeat (2) @(negedge clk);
        chk("rst_even", 32'(even_row), 0);
        chk("rst_odd", 32'(odd_row), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < L; c++) begin
                s_vec[c] = tbl[i].s;
                d_vec[c] = tbl[i].d;
                ee[c]    = tbl[i].ee;
                eo[c]    = tbl[i].eo;
            end
            run_pass(tbl[i].f, tbl[i].fl, tbl[i].pk);
            check_pass($sformatf("tbl%0d", i), tbl[i].ev, ee, eo);
            if (tbl[i].ev) begin
                chk("hold_even", 32'(even_row), 32'(tbl[i].ee));
                chk("hold_odd", 32'(odd_row), 32'(tbl[i].eo));
            end
        end

        // Round trip through a forward 5/3 model of an 8x4 block
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < L; c++)
                rx[r][c] = 8'($urandom_range(0, 255));
        for (int c = 0; c < L; c++) begin
            for (int n = 0; n < 4; n++) begin
                int x0, x1, x2;
                x0 = int'(rx[2*n][c]);
                x1 = int'(rx[2*n+1][c]);
                x2 = (n == 3) ? x0 : int'(rx[2*n+2][c]);
                rd[n][c] = 8'(x1 - ((x0 + x2) >> 1));
            end
            for (int n = 0; n < 4; n++) begin
                int dpi, dci;
                dci = int'($signed(rd[n][c]));
                dpi = (n == 0) ? dci : int'($signed(rd[n-1][c]));
                rs[n][c] = 8'(int'(rx[2*n][c]) + ((dpi + dci + 2) >>> 2));
            end
        end
        for (int p = 0; p <= 4; p++) begin
            for (int c = 0; c < L; c++) begin
                s_vec[c] = (p < 4) ? rs[p][c] : 8'h5A;
                d_vec[c] = (p < 4) ? rd[p][c] : 8'hA5;
                if (p > 0) begin
                    ee[c] = rx[2*p-2][c];
                    eo[c] = rx[2*p-1][c];
                end
            end
            run_pass(p == 0, p == 4, 1'b0);
            check_pass($sformatf("rt%0d", p), p > 0, ee, eo);
        end

        // Reset while a normal pass sits at counter=2
        for (int c = 0; c < L; c++) begin
            s_vec[c] = 8'd9;
            d_vec[c] = 8'd9;
        end
        @(negedge clk);
        en = 1'b1; first = 1'b0; flush = 1'b0;
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s_in = s_vec[c];
            d_in = d_vec[c];
            if (c < 2) @(negedge clk);
        end
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_even", 32'(even_row), 0);
        chk("mid_rst_odd", 32'(odd_row), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int c = 0; c < L; c++) begin
            s_vec[c] = 8'd50;
            d_vec[c] = 8'hFC;
            ee[c] = 8'd52;
            eo[c] = 8'd48;
        end
        run_pass(1'b1, 1'b0, 1'b0);
        check_pass("post_rst_first", 1'b0, ee, eo);
        run_pass(1'b0, 1'b1, 1'b0);
        check_pass("post_rst_flush", 1'b1, ee, eo);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/col_inverse_processor.md
Name: col_inverse_processor

Overview:
- Column-direction inverse CDF 5/3 integer lifting stage. It is the synthesis counterpart of the forward column processor.
- Consumes one low-pass (s) row and one high-pass (d) row per pass, one column per clock. Emits the reconstructed even/odd row pair of the previous pass.
- Holds the previous d row and the previous even row in two internal line banks. It sits between the coefficient store and the row-direction inverse stage of the wavelet reconstructor.

Parameters:
- LENGTH, 256, columns per row (pixels per pass); counter is clog2(LENGTH)+1 bits wide.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- en  in  1  start-pass pulse; sampled in ST_IDLE only
- first  in  1  pass carries pair 0; latched with en
- flush  in  1  final pass: no new input, mirrored boundary; latched with en
- s_in  in  8  low-pass coefficient, unsigned, column = counter
- d_in  in  8  high-pass coefficient, two's complement, column = counter
- even_row  out  8  reconstructed x[2n]
- odd_row  out  8  reconstructed x[2n+1]
- out_valid  out  1  even_row/odd_row hold a valid column
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse with last valid column of a pass

Behaviour:
- Reset (async, resetn=0): state=ST_IDLE, counter=0, latched first/flush=0, even_row=odd_row=0, out_valid=0, done=0, busy=0. Line banks are not reset.
- FSM states and transitions:
  - ST_IDLE -> ST_PROC when en=1. Latch first and flush. counter=0.
  - ST_PROC: counter increments each cycle. Column c is processed at counter=c. Exit to ST_DONE after counter=LENGTH-1.
  - ST_DONE: one cycle, then -> ST_IDLE.
- en is ignored outside ST_IDLE. busy=1 in ST_PROC and ST_DONE.
- Per column c in ST_PROC, combinational from inputs and banks (bank read of address c returns the old value before this cycle's write):
  - dc = sign-extended d_in, or dbank[c] when flush.
  - dp = dbank[c], or dc when first.
  - ep = ebank[c].
  - ec = (s_in - ((dp + dc + 2) >>> 2)) mod 256. 10-bit signed arithmetic; >>> is arithmetic (floor).
  - When flush: ec = ep (mirror, x[2N] = x[2N-2]).
  - o = (dp + ((ep + ec) >> 1)) mod 256. ep and ec are unsigned; the sum is 9-bit.
- Bank writes: at counter=c, unless flush, dbank[c] <= d_in and ebank[c] <= ec.
- Outputs are registered, latency 1 cycle: column c appears at the edge after counter=c.
  - even_row <= ep, odd_row <= o.
  - out_valid = 1 for columns 0..LENGTH-1, except out_valid stays 0 throughout a first pass (no complete pair yet).
- done = 1 in the cycle the column LENGTH-1 output is presented, whether or not out_valid is set. even_row/odd_row hold their last value when out_valid=0.
- Image of N pairs = N+1 passes: first, N-1 normal, flush.
- first=1 and flush=1 together: treat as first (single-pair images are not supported).
- Reset mid-pass: abort immediately. The next pass must be issued with first=1.

Test Plan:
- LENGTH=4, constant image: first pass s=100, d=0 on all columns -> out_valid stays 0. Normal pass s=100, d=0 -> 4 columns of even=100, odd=100. done pulses with column 3.
- Negative detail: first pass s=50, d=0xFC (-4), then flush -> even=52, odd=48 on every column. This matches forward x0=52, x1=48.
- Wrap-around: first pass s=2, d=0x7F, then flush -> even=0xC2 (194), odd=0x41 (65).
- Round trip: forward-transform a random 4x8 block with the forward column processor, feed its s/d through first + 3 normal + flush passes -> 8 output rows bit-exact to the source.
- Timing/handshake: en pulse while busy is ignored. out_valid is exactly LENGTH cycles starting 2 cycles after en. busy drops one cycle after done.
- Reset mid-pass at counter=2 -> all outputs 0 within the reset. Next first+flush sequence produces correct data.
